hilo_muldiv: RTL and testbench
==============================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have parameter MUL_LAT, default 3, giving the fixed multiply latency in cycles (at least 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port valid_i, input, 1 bit: the op_i/a_i/b_i request is valid this cycle.
REQ-006 The block SHALL have port op_i, input, 3 bits, typed mdu_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO, NOP.
REQ-007 The block SHALL have ports a_i and b_i, input, WIDTH bits each: rs and rt operands.
REQ-008 The block SHALL have port flush_i, input, 1 bit: abort any in-flight operation.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while a mul/div is in flight.
REQ-010 The block SHALL have port done_o, output, 1 bit: one-cycle pulse on the edge HI/LO commit a mul/div result.
REQ-011 The block SHALL have ports hi_o and lo_o, output, WIDTH bits each: current HI/LO, feeding the EX result mux data inputs.

Function
REQ-012 The FSM SHALL use states IDLE, MUL, DIV.
REQ-013 In IDLE, valid_i with MULT/MULTU SHALL go to MUL; with DIV/DIVU it SHALL go to DIV; busy_o SHALL be asserted from the next cycle.
REQ-014 In IDLE, valid_i with MTHI/MTLO SHALL write a_i into HI/LO on that edge (1-cycle latency), with no busy_o and no done_o.
REQ-015 valid_i while busy_o=1 SHALL be ignored; upstream stalls on busy_o.
REQ-016 Operands SHALL be latched at acceptance; later changes to a_i/b_i SHALL have no effect.
REQ-017 MUL SHALL return to IDLE exactly MUL_LAT cycles after acceptance, writing {HI,LO} with the 2*WIDTH product (signed for MULT, unsigned for MULTU) and pulsing done_o.
REQ-018 DIV SHALL be radix-2 restoring on magnitudes and take exactly WIDTH+1 cycles from acceptance to commit: LO=quotient, HI=remainder.
REQ-019 For signed DIV, quotient sign SHALL be sign(a)^sign(b) and remainder sign SHALL equal sign(a).
REQ-020 On divide by zero (both DIV and DIVU), the result SHALL be LO=all-ones and HI=a, committed on the normal schedule.
REQ-021 DIV of the most negative value by -1 SHALL give LO=most negative value, HI=0.
REQ-022 flush_i SHALL force IDLE on the next edge with HI/LO unchanged and no done_o; flush_i in the commit cycle SHALL suppress the commit.
REQ-023 flush_i together with valid_i in IDLE SHALL discard the request, including MTHI/MTLO.
REQ-024 hi_o/lo_o SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-025 On rst=1, the block SHALL asynchronously set state=IDLE, HI=0, LO=0, busy_o=0, done_o=0, and clear the counters and operand latches.
REQ-026 Reset asserted mid-operation SHALL abandon the operation; after release the block SHALL accept a new request in the first cycle.

Structure
REQ-027 Package mdu_pkg SHALL hold mdu_op_t, the state enum, and the MUL_LAT default constant.
REQ-028 The iterative divider SHALL be sub-module div_iter, with start, signed flag, operands, done and quotient/remainder ports; the FSM and HI/LO stay in hilo_muldiv.

Verification
REQ-029 MULT a=0xFFFFFFFE (-2), b=3 -> done_o at cycle 3; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 DIV a=-7, b=2 -> done_o at cycle 33; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi_o=0x1234 and lo_o=0x5678 one cycle after each, busy_o stays 0.
REQ-033 DIVU started, flush_i at cycle 10, then MULTU 5*5 -> no done_o for DIVU, HI/LO keep old values, then HI=0, LO=25.
REQ-034 rst pulsed at cycle 5 of DIV -> outputs zero immediately; a new MULT issued the cycle after release completes normally.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared types for the HI/LO multiply-divide unit: opcode encoding,
// controller state encoding and the default multiply latency.
package mdu_pkg;

    // Operation requested alongside valid_i
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_t;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_t;

    // Fixed number of cycles from multiply acceptance to HI/LO commit
    localparam int MDU_MUL_LAT = 3;

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// Iterative radix-2 restoring divider working on operand magnitudes.
// A start pulse latches the operands; WIDTH iteration cycles follow, after
// which o_done stays high (with the sign-corrected result on o_quot/o_rem)
// until the next edge, when the unit goes idle again.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    localparam int CW = $clog2(WIDTH + 1);

    // Magnitude of a value that is two's complement only when s is set
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Re-apply a sign to an unsigned magnitude
    function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic          r_run;
    logic [CW-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_a;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_bzero;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_sub;
    logic             w_fits;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The subtraction is only
    // kept when it fits, so its low WIDTH bits are the exact new remainder.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_fits   = (w_rem_sh >= {1'b0, r_div});
    assign w_sub    = w_rem_sh[WIDTH-1:0] - r_div;

    // Latch operands on start, iterate WIDTH times, then hold done one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_a     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bzero <= 1'b0;
        end else if (i_abort) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= f_mag(i_a, i_signed);
            r_div   <= f_mag(i_b, i_signed);
            r_a     <= i_a;
            r_neg_q <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= i_signed & i_a[WIDTH-1];
            r_bzero <= (i_b == '0);
        end else if (r_run) begin
            if (r_cnt == CW'(WIDTH)) begin
                r_run <= 1'b0;
            end else begin
                r_rem <= w_fits ? w_sub : w_rem_sh[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_fits};
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Divide by zero bypasses the iteration result: quotient all-ones,
    // remainder the original dividend. The most-negative / -1 case needs no
    // special handling: its quotient magnitude negates back onto itself.
    assign o_done = r_run && (r_cnt == CW'(WIDTH));
    assign o_quot = r_bzero ? '1  : f_apply_sign(r_quo, r_neg_q);
    assign o_rem  = r_bzero ? r_a : f_apply_sign(r_rem, r_neg_r);

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit. Accepts one operation at a time from IDLE,
// commits the multiply product after MUL_LAT cycles and the divide result
// after WIDTH+1 cycles, and handles MTHI/MTLO as single-cycle writes.
module hilo_muldiv
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MDU_MUL_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  mdu_op_t          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    mdu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic                      w_accept;
    logic                      w_div_start;
    logic                      w_div_signed;
    logic                      w_div_done;
    logic [WIDTH-1:0]          w_div_quot;
    logic [WIDTH-1:0]          w_div_rem;
    logic                      w_mul_last;
    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;

    assign w_accept     = (r_state == IDLE) && valid_i && !flush_i;
    assign w_div_start  = w_accept && ((op_i == OP_DIV) || (op_i == OP_DIVU));
    assign w_div_signed = (op_i == OP_DIV);
    assign w_mul_last   = (r_cnt == CNT_W'(MUL_LAT - 1));

    // Extending both operands to 2*WIDTH (sign or zero by opcode) lets one
    // multiplier serve MULT and MULTU: the low 2*WIDTH bits are exact.
    assign w_a_ext = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_b_ext = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_div_start),
        .i_abort  (flush_i),
        .i_signed (w_div_signed),
        .i_a      (a_i),
        .i_b      (b_i),
        .o_done   (w_div_done),
        .o_quot   (w_div_quot),
        .o_rem    (w_div_rem)
    );

    // Controller: accept requests in IDLE, count the multiply latency, wait
    // for the divider, and commit HI/LO with a one-cycle done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (op_i)
                            OP_MULT, OP_MULTU: begin
                                r_state  <= MUL;
                                r_busy   <= 1'b1;
                                r_cnt    <= '0;
                                r_a      <= a_i;
                                r_b      <= b_i;
                                r_signed <= (op_i == OP_MULT);
                            end
                            OP_DIV, OP_DIVU: begin
                                r_state <= DIV;
                                r_busy  <= 1'b1;
                            end
                            OP_MTHI: r_hi <= a_i;
                            OP_MTLO: r_lo <= a_i;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_mul_last) begin
                        r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo    <= w_prod[WIDTH-1:0];
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_div_done) begin
                        r_hi    <= w_div_rem;
                        r_lo    <= w_div_quot;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv with a cycle-level reference model.
module tb_hilo_muldiv;
    import mdu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    mdu_op_t       op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          flush_i;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    bit           m_busy = 1'b0, m_done = 1'b0;
    int           m_left = 0;

    hilo_muldiv #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} of a mul/div, from plain arithmetic
    function automatic logic [63:0] exp_res(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                return up;
            end
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Model step at a rising edge, driven only by the inputs seen there
    task automatic model_edge();
        logic [63:0] r;
        m_done = 1'b0;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_left = 0;
            return;
        end
        if (m_busy) begin
            if (flush_i) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_phi; m_lo = m_plo; m_done = 1'b1; m_busy = 1'b0;
                end
            end
        end else if (valid_i && !flush_i) begin
            case (op_i)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    r = exp_res(op_i, a_i, b_i);
                    m_phi  = r[63:32];
                    m_plo  = r[31:0];
                    m_busy = 1'b1;
                    m_left = (op_i == OP_MULT || op_i == OP_MULTU) ? LAT : W + 1;
                end
                OP_MTHI: m_hi = a_i;
                OP_MTLO: m_lo = a_i;
                default: ;
            endcase
        end
    endtask

    // One clock: model update at the rising edge, full compare at the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("busy_o", 32'(busy_o), 32'(m_busy));
        chk("done_o", 32'(done_o), 32'(m_done));
        chk("hi_o", hi_o, m_hi);
        chk("lo_o", lo_o, m_lo);
    endtask

    // Issue one mul/div, scramble operands after acceptance, wait for done
    task automatic do_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit junk, output int lat);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        tick();
        valid_i = junk; op_i = junk ? OP_MTHI : OP_NOP;
        a_i = $urandom; b_i = $urandom;
        lat = 0;
        while (!done_o && lat < 60) begin
            tick();
            lat++;
        end
        valid_i = 1'b0; op_i = OP_NOP;
    endtask

    initial begin
        int lat;
        bit saw_done;
        rst = 1'b1; valid_i = 1'b0; op_i = OP_NOP; a_i = '0; b_i = '0; flush_i = 1'b0;
        tick();
        tick();
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst = 1'b0;
        tick();

        // Signed multiply
        do_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, lat);
        chk("mult_lat", lat, 3);
        chk("mult_hi", hi_o, 32'hFFFFFFFF);
        chk("mult_lo", lo_o, 32'hFFFFFFFA);

        // Signed divide, with requests held valid while busy
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, lat);
        chk("div_lat", lat, 33);
        chk("div_lo", lo_o, 32'hFFFFFFFD);
        chk("div_hi", hi_o, 32'hFFFFFFFF);

        do_op(OP_DIVU, 32'd7, 32'd0, 1'b0, lat);
        chk("divu0_lo", lo_o, 32'hFFFFFFFF);
        chk("divu0_hi", hi_o, 32'd7);

        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
        chk("divovf_lo", lo_o, 32'h80000000);
        chk("divovf_hi", hi_o, 32'h0);

        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat);
        chk("multu_hi", hi_o, 32'hFFFFFFFE);
        chk("multu_lo", lo_o, 32'h00000001);

        do_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, lat);
        chk("div_negb_lo", lo_o, 32'hFFFFFFFD);
        chk("div_negb_hi", hi_o, 32'h00000001);

        do_op(OP_DIV, 32'hFFFFFFF8, 32'd0, 1'b0, lat);
        chk("div0s_lo", lo_o, 32'hFFFFFFFF);
        chk("div0s_hi", hi_o, 32'hFFFFFFF8);

        do_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, 1'b0, lat);
        chk("divu_lo", lo_o, 32'h7FFFFFFC);
        chk("divu_hi", hi_o, 32'h00000001);

        // MTHI then MTLO back to back
        valid_i = 1'b1; op_i = OP_MTHI; a_i = 32'h1234;
        tick();
        chk("mthi_hi", hi_o, 32'h1234);
        chk("mthi_busy", 32'(busy_o), 32'h0);
        op_i = OP_MTLO; a_i = 32'h5678;
        tick();
        chk("mtlo_lo", lo_o, 32'h5678);
        chk("mtlo_hi", hi_o, 32'h1234);
        chk("mtlo_busy", 32'(busy_o), 32'h0);
        valid_i = 1'b0; op_i = OP_NOP;

        // Flush together with a request in IDLE discards it
        valid_i = 1'b1; op_i = OP_MTHI; a_i = 32'hDEAD; flush_i = 1'b1;
        tick();
        valid_i = 1'b0; op_i = OP_NOP; flush_i = 1'b0;
        tick();
        chk("flush_mthi_hi", hi_o, 32'h1234);

        // Flush a divide part-way through, then multiply
        do_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, lat);
        valid_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
        tick();
        valid_i = 1'b0; op_i = OP_NOP;
        saw_done = 1'b0;
        repeat (9) begin tick(); saw_done |= done_o; end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (30) begin tick(); saw_done |= done_o; end
        chk("flush_div_done", 32'(saw_done), 32'h0);
        chk("flush_div_busy", 32'(busy_o), 32'h0);
        chk("flush_div_hi", hi_o, 32'hFFFFFFFF);
        chk("flush_div_lo", lo_o, 32'hFFFFFFFA);
        do_op(OP_MULTU, 32'd5, 32'd5, 1'b0, lat);
        chk("post_flush_lat", lat, 3);
        chk("post_flush_hi", hi_o, 32'h0);
        chk("post_flush_lo", lo_o, 32'd25);

        // Flush landing exactly on the multiply commit edge
        valid_i = 1'b1; op_i = OP_MULT; a_i = 32'd2; b_i = 32'd3;
        tick();
        valid_i = 1'b0; op_i = OP_NOP;
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_commit_done", 32'(done_o), 32'h0);
        chk("flush_commit_lo", lo_o, 32'd25);
        tick();
        chk("flush_commit_busy", 32'(busy_o), 32'h0);

        // Reset in the middle of a divide, then a multiply right after release
        valid_i = 1'b1; op_i = OP_DIV; a_i = 32'd100; b_i = 32'd3;
        tick();
        valid_i = 1'b0; op_i = OP_NOP;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("midrst_hi", hi_o, 32'h0);
        chk("midrst_lo", lo_o, 32'h0);
        chk("midrst_busy", 32'(busy_o), 32'h0);
        tick();
        rst = 1'b0;
        do_op(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFC, 1'b0, lat);
        chk("after_rst_lat", lat, 3);
        chk("after_rst_hi", hi_o, 32'h0);
        chk("after_rst_lo", lo_o, 32'd12);
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
